// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
// Counter width helper plus the output hold-register state encoding.
package deser_pkg;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/deser_n_if.sv
// Serial-in / word-out handshake bundle for deser_n.
// slave: the deserializer side; master: the producer/consumer side.
interface deser_n_if
  import deser_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic                      sin;
  logic                      sin_valid;
  logic                      sin_ready;
  logic                      sin_clear;
  logic [WIDTH-1:0]          word;
  logic                      word_valid;
  logic                      word_ready;
  logic [cnt_w(WIDTH)-1:0]   bit_count;

  modport slave (
    input  sin, sin_valid, sin_clear, word_ready,
    output sin_ready, word, word_valid, bit_count
  );

  modport master (
    output sin, sin_valid, sin_clear, word_ready,
    input  sin_ready, word, word_valid, bit_count
  );
endinterface

// File: rtl/andN.sv
// WIDTH-input AND reduction; purely combinational, no flow control.
// Downstream consumer of the assembled word.
module andN #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic             y
);
  assign y = &a;
endmodule

// File: rtl/deser_n_shift_in_reg.sv
// Enabled shift register with synchronous clear; exposes the value it would take on a shift.
// One cycle per shift; no flow control of its own (caller gates en).
module shift_in_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] shifted
);
  logic [WIDTH-1:0] q;

  // MSB-first shifts left so the oldest bit walks up to the MSB; LSB-first mirrors it.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {q[WIDTH-2:0], din};
    end else begin : g_lsb
      assign shifted = {din, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= shifted;
    end
  end
endmodule

// File: rtl/deser_n.sv
// Serial-to-parallel deserializer with a one-word hold register; word_valid rises on the edge accepting bit WIDTH.
// Stalls sin only when the final bit would land on an occupied, untaken hold register.
module deser_n
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic       clk,
  input logic       reset,
  deser_n_if.slave  bus
);
  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_q;
  out_state_t       state, state_nxt;
  logic             last, ready, accept, shift_en, complete, clr, take, valid;

  assign valid    = (state == FULL);
  assign last     = (cnt == LAST);
  assign ready    = ~(valid & ~bus.word_ready & last);
  // sin_clear wins over a simultaneous accept, so the bit is simply dropped.
  assign accept   = bus.sin_valid & ready & ~bus.sin_clear;
  assign complete = accept & last;
  assign shift_en = accept & ~last;
  assign clr      = bus.sin_clear | complete;
  assign take     = valid & bus.word_ready;

  shift_in_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk     (clk),
    .reset   (reset),
    .en      (shift_en),
    .clr     (clr),
    .din     (bus.sin),
    .shifted (shifted)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else if (complete) begin
      word_q <= shifted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A take and a completion in the same cycle keep FULL, giving back-to-back words.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (complete) state_nxt = FULL;
      FULL:    if (take && !complete) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign bus.sin_ready  = ready;
  assign bus.word       = word_q;
  assign bus.word_valid = valid;
  assign bus.bit_count  = cnt;
endmodule

// File: tb/tb_deser_n.sv
// Directed bench for deser_n (MSB-first and LSB-first instances) feeding andN.
module tb_deser_n;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic y, y2;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic held_prev = 1'b0;
  logic [WIDTH-1:0] prev_word = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  deser_n_if #(.WIDTH(WIDTH)) bus ();
  deser_n_if #(.WIDTH(WIDTH)) bus2 ();

  deser_n #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  deser_n #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  andN #(.WIDTH(WIDTH)) u_and  (.a(bus.word),  .y(y));
  andN #(.WIDTH(WIDTH)) u_and2 (.a(bus2.word), .y(y2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    bus.sin       = b;
    bus.sin_valid = 1'b1;
    tick();
  endtask

  task automatic send2(input logic b);
    bus2.sin       = b;
    bus2.sin_valid = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send(v[i]);
  endtask

  // A held, untaken word must stay valid and unchanged; andN must track the word.
  always @(negedge clk) begin
    if (reset) begin
      held_prev <= 1'b0;
    end else begin
      if (held_prev) begin
        chk("hold_valid", bus.word_valid, 1);
        chk("hold_word", bus.word, prev_word);
      end
      if (bus.word_valid) chk("andn_track", y, &bus.word);
      held_prev <= bus.word_valid & ~bus.word_ready;
      prev_word <= bus.word;
    end
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] data;
    int         last_cyc;

    reset = 1'b1;
    bus.sin = 0; bus.sin_valid = 0; bus.sin_clear = 0; bus.word_ready = 0;
    bus2.sin = 0; bus2.sin_valid = 0; bus2.sin_clear = 0; bus2.word_ready = 1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_word", bus.word, 8'h00);
    chk("rst_valid", bus.word_valid, 0);
    chk("rst_cnt", bus.bit_count, 0);
    chk("rst_ready", bus.sin_ready, 1);

    // Basic MSB-first word 0xB2 with bit_count walk
    bus.word_ready = 1;
    pat = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      chk("cnt_seq", bus.bit_count, i);
      send(pat[7-i]);
    end
    chk("b2_cnt", bus.bit_count, 0);
    chk("b2_valid", bus.word_valid, 1);
    chk("b2_word", bus.word, 8'hB2);
    chk("b2_y", y, 0);
    bus.sin_valid = 0;
    tick();
    chk("b2_pulse", bus.word_valid, 0);

    // All-ones then 0xFE into andN
    send_byte(8'hFF);
    chk("ff_word", bus.word, 8'hFF);
    chk("ff_y", y, 1);
    send_byte(8'hFE);
    chk("fe_word", bus.word, 8'hFE);
    chk("fe_y", y, 0);
    bus.sin_valid = 0;
    tick();

    // LSB-first instance: same stream 1111111 then 0
    for (int i = 0; i < 7; i++) send2(1'b1);
    send2(1'b0);
    bus2.sin_valid = 0;
    chk("lsb_valid", bus2.word_valid, 1);
    chk("lsb_word", bus2.word, 8'h7F);
    chk("lsb_y", y2, 0);
    tick();

    // Backpressure: 0xA5 held, 0x3C stalls on its last bit
    bus.word_ready = 0;
    send_byte(8'hA5);
    chk("a5_valid", bus.word_valid, 1);
    chk("a5_word", bus.word, 8'hA5);
    pat = 8'h3C;
    for (int i = 0; i < 7; i++) send(pat[7-i]);
    chk("bp_cnt7", bus.bit_count, 7);
    bus.sin = pat[0];
    bus.sin_valid = 1;
    #1;
    chk("bp_ready_lo", bus.sin_ready, 0);
    tick();
    chk("bp_stall_cnt", bus.bit_count, 7);
    chk("bp_stall_word", bus.word, 8'hA5);
    bus.word_ready = 1;
    #1;
    chk("bp_ready_hi", bus.sin_ready, 1);
    tick();
    bus.word_ready = 0;
    bus.sin_valid = 0;
    chk("3c_word", bus.word, 8'h3C);
    chk("3c_valid", bus.word_valid, 1);
    chk("3c_cnt", bus.bit_count, 0);
    tick();
    chk("3c_still", bus.word, 8'h3C);

    // Clear drops partial word and the simultaneous bit, leaves held word alone
    for (int i = 0; i < 4; i++) send(1'b1);
    chk("clr_pre_cnt", bus.bit_count, 4);
    bus.sin_clear = 1;
    send(1'b1);
    bus.sin_clear = 0;
    bus.sin_valid = 0;
    chk("clr_cnt", bus.bit_count, 0);
    chk("clr_word", bus.word, 8'h3C);
    chk("clr_valid", bus.word_valid, 1);
    bus.word_ready = 1;
    send_byte(8'h0F);
    bus.word_ready = 0;
    bus.sin_valid = 0;
    chk("0f_word", bus.word, 8'h0F);
    chk("0f_valid", bus.word_valid, 1);

    // Asynchronous reset mid-word with a word held
    send(1); send(0); send(1); send(0); send(1);
    bus.sin_valid = 0;
    chk("pre_rst_cnt", bus.bit_count, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_word", bus.word, 8'h00);
    chk("arst_valid", bus.word_valid, 0);
    chk("arst_cnt", bus.bit_count, 0);
    tick();
    reset = 1'b0;
    bus.word_ready = 1;
    send_byte(8'hC3);
    chk("c3_word", bus.word, 8'hC3);
    chk("c3_valid", bus.word_valid, 1);

    // Throughput: 10 back-to-back words, one every 8 cycles
    last_cyc = 0;
    for (int w = 0; w < 10; w++) begin
      data = 8'($urandom_range(0, 255));
      for (int b = 7; b >= 0; b--) begin
        send(data[b]);
        if (b != 0) chk("tp_gap_lo", bus.word_valid, 0);
      end
      chk("tp_valid", bus.word_valid, 1);
      chk("tp_word", bus.word, data);
      chk("tp_y", y, &data);
      if (w > 0) chk("tp_period", cyc - last_cyc, 8);
      last_cyc = cyc;
    end
    bus.sin_valid = 0;
    tick();
    chk("tp_drain", bus.word_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/deser_n.md
Name: deser_n

Overview:
- Serial-to-parallel deserializer that assembles WIDTH serial bits into one word.
- Presents each word through a valid/ready handshake to the WIDTH-bit reduction stage downstream (andN, orN and similar).
- Upstream side uses a serial bit valid/ready handshake.
- Provides one word of output buffering, so a new word can be shifted in while the previous word waits for the consumer.

Parameters:
- WIDTH, 8, word width in bits (>=2); matches the downstream reduction width.
- MSB_FIRST, 1, 1: first accepted bit lands in word[WIDTH-1]; 0: first accepted bit lands in word[0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_ready  output  1  block accepts sin this cycle.
- sin_clear  input  1  synchronous abort of the partially assembled word.
- word  output  WIDTH  assembled word, held stable while word_valid=1.
- word_valid  output  1  word holds an unconsumed word.
- word_ready  input  1  consumer takes word this cycle.
- bit_count  output  $clog2(WIDTH+1)  bits currently held in the shift register (0..WIDTH-1).

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: shift register 0, bit_count 0, word 0, word_valid 0.
- Reset mid-word discards the partial word and any held word.
- Accept condition: accept = sin_valid & sin_ready.
- Transfer condition: take = word_valid & word_ready.
- sin_ready = ~(word_valid & ~word_ready & bit_count==WIDTH-1).
  - Backpressure applies only when the final bit would need the occupied hold register.
  - sin_ready is combinational from word_ready; no dependence on sin_valid.
- On accept with bit_count < WIDTH-1:
  - Shift the bit in per MSB_FIRST. MSB-first shifts left with the new bit in the LSB, so the first bit ends at the MSB.
  - bit_count += 1.
- On accept with bit_count == WIDTH-1 (completion):
  - word <= full assembled word including this bit.
  - word_valid <= 1.
  - bit_count <= 0.
  - Shift register cleared to 0.
- Latency: word_valid rises on the clock edge that accepts the WIDTH-th bit. Word is visible the cycle after the final bit is presented.
- Output states:
  - EMPTY (word_valid=0) -> FULL on completion.
  - FULL -> EMPTY on take without completion.
  - FULL stays FULL when take and completion occur in the same cycle; word reloads with the new value and there is no bubble.
- Sustained throughput: one word per WIDTH cycles with no stall when word_ready is held high.
- word changes only on completion and never while word_valid=1 && ~word_ready.
- sin_clear:
  - Resets bit_count and the shift register to 0 on the next edge.
  - Priority over a simultaneous accept; that bit is dropped.
  - No effect on word or word_valid.
- sin_valid=0: shift register and bit_count hold.
- word_ready while word_valid=0 has no effect.
- Overrun is impossible by construction, so there is no flag. Bench asserts that no completion occurs while FULL and not taken.

Decomposition:
- Shared package deser_pkg:
  - Localparam function for the counter width (clog2 of WIDTH+1).
  - Enum out_state_t {EMPTY, FULL} for the output register state.
- One natural sub-module, shift_in_reg:
  - Parameterised WIDTH/MSB_FIRST shift register with enable, synchronous clear and asynchronous reset.
  - deser_n wraps it with the counter, hold register and handshake logic.
- Bench instantiates deser_n feeding andN #(WIDTH) on word to check the system-level all-ones result.

Test Plan:
- Reset: assert reset asynchronously mid-cycle after 5 accepted bits -> word=0, word_valid=0, bit_count=0 immediately; next 8 bits form a fresh word.
- Basic MSB-first, WIDTH=8: word_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> word_valid=1 for one cycle after the 8th edge, word=8'hB2; bit_count sequence 0..7 then 0.
- All-ones into andN: shift 8 ones then 8'b11111110 with the zero last -> first word 8'hFF with andN y=1, second word 8'hFE with y=0. With MSB_FIRST=0, the same stream gives 8'h7F and y=0.
- Backpressure: word_ready=0, stream 16 bits of 8'hA5 then 8'h3C -> first word 8'hA5 held. After 7 more bits sin_ready=0 and 16th bit stalls. Raise word_ready for one cycle -> 8'hA5 taken, 8th bit accepted in the same cycle, word=8'h3C next cycle, word_valid stays 1.
- Clear: 4 bits 1,1,1,1 accepted, then sin_clear=1 with sin_valid=1 -> bit dropped, bit_count=0; next 8 bits 0x0F -> word=8'h0F, and the held word is untouched by the clear.
- Throughput: 10 back-to-back random words with word_ready=1 -> 10 word_valid pulses exactly 8 cycles apart; each word matches the scoreboard and its andN y equals &word.
